// File: rtl/div_seq_if.sv
// Bundles the request, divider-side and result channels of div_seq; slave is the sequencer's view.
interface div_seq_if #(
   parameter int DW = 32
);
   logic          s_valid_i;
   logic          s_ready_o;
   logic [DW-1:0] s_a_i;
   logic [DW-1:0] s_b_i;

   logic          div_start_o;
   logic [DW-1:0] div_a_o;
   logic [DW-1:0] div_b_o;
   logic          div_ready_i;
   logic [DW-1:0] div_quotient_i;
   logic [DW-1:0] div_remainder_i;

   logic          m_valid_o;
   logic          m_ready_i;
   logic [DW-1:0] m_quotient_o;
   logic [DW-1:0] m_remainder_o;
   logic          m_dz_o;
   logic          busy_o;

   modport slave (
      input  s_valid_i, s_a_i, s_b_i, div_ready_i, div_quotient_i, div_remainder_i, m_ready_i,
      output s_ready_o, div_start_o, div_a_o, div_b_o, m_valid_o, m_quotient_o, m_remainder_o,
             m_dz_o, busy_o
   );

   modport master (
      output s_valid_i, s_a_i, s_b_i, div_ready_i, div_quotient_i, div_remainder_i, m_ready_i,
      input  s_ready_o, div_start_o, div_a_o, div_b_o, m_valid_o, m_quotient_o, m_remainder_o,
             m_dz_o, busy_o
   );
endinterface

// File: rtl/div_seq.sv
// One-at-a-time sequencer around a fixed-latency pipelined divider; result held until m_ready_i.
// Define DIV_SEQ_ZERO_CHECK_EN to short-circuit b==0 to a flagged result without using the divider.
module div_seq #(
   parameter int DW      = 32,
   parameter int DIV_LAT = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   div_seq_if.slave    io
);

   if (DIV_LAT < 1 || DIV_LAT > 255) begin : g_lat_check
      $error("div_seq: DIV_LAT must be within 1..255");
   end

   localparam logic [7:0] LAT_M1 = 8'(DIV_LAT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   state_t        state;
   logic [7:0]    cnt;
   logic [DW-1:0] a_q;
   logic [DW-1:0] b_q;
   logic [DW-1:0] q_q;
   logic [DW-1:0] r_q;
   logic          m_valid_q;
   logic          start_q;
   logic          busy_q;
   logic          s_ready_q;
`ifdef DIV_SEQ_ZERO_CHECK_EN
   logic          dz_q;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         q_q       <= '0;
         r_q       <= '0;
         m_valid_q <= 1'b0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         s_ready_q <= 1'b1;
`ifdef DIV_SEQ_ZERO_CHECK_EN
         dz_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (io.s_valid_i) begin
                  a_q       <= io.s_a_i;
                  b_q       <= io.s_b_i;
                  s_ready_q <= 1'b0;
                  busy_q    <= 1'b1;
`ifdef DIV_SEQ_ZERO_CHECK_EN
                  // Zero divisor never reaches the divider; answer is formed here.
                  if (io.s_b_i == '0) begin
                     q_q       <= '1;
                     r_q       <= io.s_a_i;
                     dz_q      <= 1'b1;
                     m_valid_q <= 1'b1;
                     state     <= HOLD;
                  end else begin
                     start_q <= 1'b1;
                     state   <= ISSUE;
                  end
`else
                  start_q <= 1'b1;
                  state   <= ISSUE;
`endif
               end
            end
            ISSUE: begin
               start_q <= 1'b0;
               cnt     <= LAT_M1;
               state   <= WAIT;
            end
            WAIT: begin
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else if (io.div_ready_i) begin
                  q_q       <= io.div_quotient_i;
                  r_q       <= io.div_remainder_i;
                  m_valid_q <= 1'b1;
                  state     <= HOLD;
`ifdef DIV_SEQ_ZERO_CHECK_EN
                  dz_q      <= 1'b0;
`endif
               end
            end
            HOLD: begin
               if (io.m_ready_i) begin
                  m_valid_q <= 1'b0;
                  s_ready_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign io.s_ready_o     = s_ready_q;
   assign io.div_start_o   = start_q;
   assign io.div_a_o       = a_q;
   assign io.div_b_o       = b_q;
   assign io.m_valid_o     = m_valid_q;
   assign io.m_quotient_o  = q_q;
   assign io.m_remainder_o = r_q;
   assign io.busy_o        = busy_q;
`ifdef DIV_SEQ_ZERO_CHECK_EN
   assign io.m_dz_o        = dz_q;
`else
   assign io.m_dz_o        = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq with a behavioural fixed-latency divider alongside.
module tb_div_seq;
   localparam int DW      = 32;
   localparam int DIV_LAT = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   stall_n  = 0;

   div_seq_if #(.DW(DW)) bus ();

   div_seq #(.DW(DW), .DIV_LAT(DIV_LAT)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .io    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Divider model: result presented DIV_LAT cycles after the start pulse, optionally stalled.
   initial begin : divider_model
      logic [DW-1:0] ma, mb;
      int            mcnt;
      bit            mbusy;
      ma = '0; mb = '0; mcnt = 0; mbusy = 0;
      bus.div_ready_i     = 1'b0;
      bus.div_quotient_i  = 32'hDEADBEEF;
      bus.div_remainder_i = 32'hDEADBEEF;
      forever begin
         @(negedge clk);
         if (bus.div_start_o) begin
            ma = bus.div_a_o;
            mb = bus.div_b_o;
            mcnt = DIV_LAT;
            mbusy = 1;
            bus.div_ready_i     = 1'b0;
            bus.div_quotient_i  = 32'hDEADBEEF;
            bus.div_remainder_i = 32'hDEADBEEF;
         end else if (mbusy) begin
            if (mcnt > 1) mcnt--;
            else if (stall_n > 0) stall_n--;
            else begin
               bus.div_ready_i     = 1'b1;
               bus.div_quotient_i  = (mb == 0) ? '1 : ma / mb;
               bus.div_remainder_i = (mb == 0) ? ma : ma % mb;
               mbusy = 0;
            end
         end
      end
   end

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int stall, input int hold, input int exp_lat, input int exp_starts,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz);
      int lat, starts, st_cyc, bad;
      @(negedge clk);
      stall_n = stall;
      bus.m_ready_i = (hold == 0);
      bus.s_a_i = a;
      bus.s_b_i = b;
      bus.s_valid_i = 1'b1;
      chk({tag, "_srdy_idle"}, bus.s_ready_o, 1);
      @(posedge clk);
      lat = 0; starts = 0; st_cyc = -1;
      @(negedge clk);
      bus.s_valid_i = 1'b0;
      bus.s_a_i = 32'hA5A5A5A5;
      bus.s_b_i = 32'h5A5A5A5A;
      for (int i = 1; i <= 200; i++) begin
         if (i > 1) @(negedge clk);
         if (bus.div_start_o) begin
            starts++;
            if (st_cyc < 0) st_cyc = i;
            chk({tag, "_div_a"}, bus.div_a_o, a);
            chk({tag, "_div_b"}, bus.div_b_o, b);
         end
         if (bus.m_valid_o) begin
            lat = i;
            break;
         end
      end
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_starts"}, starts, exp_starts);
      if (exp_starts > 0) chk({tag, "_start_cyc"}, st_cyc, 1);
      chk({tag, "_quot"}, bus.m_quotient_o, eq);
      chk({tag, "_rem"}, bus.m_remainder_o, er);
      chk({tag, "_dz"}, bus.m_dz_o, edz);
      chk({tag, "_busy"}, bus.busy_o, 1);
      chk({tag, "_srdy_busy"}, bus.s_ready_o, 0);
      if (hold > 0) begin
         bad = 0;
         repeat (hold) begin
            @(negedge clk);
            if (!bus.m_valid_o || bus.m_quotient_o != eq || bus.m_remainder_o != er ||
                bus.m_dz_o != edz || bus.s_ready_o) bad++;
         end
         chk({tag, "_hold_stable"}, bad, 0);
         bus.m_ready_i = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_mvalid_after"}, bus.m_valid_o, 0);
      chk({tag, "_srdy_after"}, bus.s_ready_o, 1);
      chk({tag, "_busy_after"}, bus.busy_o, 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int bad, k;
      bit pend;
      int acc[3];
      logic [31:0] opa[3], opb[3], rq[$], rr[$];
      bus.s_valid_i = 1'b0;
      bus.s_a_i = '0;
      bus.s_b_i = '0;
      bus.m_ready_i = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_srdy", bus.s_ready_o, 1);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_mvalid", bus.m_valid_o, 0);
      chk("rst_start", bus.div_start_o, 0);
      chk("rst_quot", bus.m_quotient_o, 0);
      chk("rst_dz", bus.m_dz_o, 0);
      rst = 1'b0;

      run_op("basic", 32'd100, 32'd7, 0, 0, 34, 1, 32'd14, 32'd2, 1'b0);
      run_op("hold", 32'd1000, 32'd33, 0, 10, 34, 1, 32'd30, 32'd10, 1'b0);
      run_op("stall", 32'd12345, 32'd100, 5, 0, 39, 1, 32'd123, 32'd45, 1'b0);
`ifdef DIV_SEQ_ZERO_CHECK_EN
      run_op("dz", 32'h55, 32'd0, 0, 0, 1, 0, 32'hFFFFFFFF, 32'h55, 1'b1);
`else
      run_op("b0", 32'h55, 32'd0, 0, 0, 34, 1, 32'hFFFFFFFF, 32'h55, 1'b0);
`endif

      // Reset in the middle of a divide.
      @(negedge clk);
      bus.m_ready_i = 1'b1;
      bus.s_a_i = 32'd1000;
      bus.s_b_i = 32'd10;
      bus.s_valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.s_valid_i = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_srdy", bus.s_ready_o, 1);
      chk("mid_rst_busy", bus.busy_o, 0);
      chk("mid_rst_mvalid", bus.m_valid_o, 0);
      chk("mid_rst_start", bus.div_start_o, 0);
      chk("mid_rst_div_a", bus.div_a_o, 0);
      chk("mid_rst_quot", bus.m_quotient_o, 0);
      chk("mid_rst_rem", bus.m_remainder_o, 0);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (bus.m_valid_o || bus.div_start_o || bus.busy_o) bad++;
      end
      chk("mid_rst_quiet", bad, 0);
      run_op("post_rst", 32'd99, 32'd10, 0, 0, 34, 1, 32'd9, 32'd9, 1'b0);

      // Three requests with s_valid_i held high and m_ready_i tied high.
      opa[0] = 32'd1000; opb[0] = 32'd3;
      opa[1] = 32'd77;   opb[1] = 32'd77;
      opa[2] = 32'd5;    opb[2] = 32'd9;
      k = 0; pend = 0;
      @(negedge clk);
      stall_n = 0;
      bus.m_ready_i = 1'b1;
      bus.s_a_i = opa[0];
      bus.s_b_i = opb[0];
      bus.s_valid_i = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (bus.m_valid_o) begin
            rq.push_back(bus.m_quotient_o);
            rr.push_back(bus.m_remainder_o);
         end
         if (bus.s_valid_i && bus.s_ready_o && k < 3) begin
            acc[k] = cyc;
            k++;
            pend = 1;
         end
         if (k == 3 && rq.size() >= 3) break;
         @(negedge clk);
         if (pend) begin
            pend = 0;
            if (k < 3) begin
               bus.s_a_i = opa[k];
               bus.s_b_i = opb[k];
            end else begin
               bus.s_valid_i = 1'b0;
            end
         end
      end
      chk("b2b_accepts", k, 3);
      chk("b2b_results", rq.size(), 3);
      if (k == 3) begin
         chk("b2b_gap01", acc[1] - acc[0], 35);
         chk("b2b_gap12", acc[2] - acc[1], 35);
      end
      if (rq.size() >= 3) begin
         chk("b2b_q0", rq[0], 32'd333);
         chk("b2b_r0", rr[0], 32'd1);
         chk("b2b_q1", rq[1], 32'd1);
         chk("b2b_r1", rr[1], 32'd0);
         chk("b2b_q2", rq[2], 32'd0);
         chk("b2b_r2", rr[2], 32'd5);
      end
      @(negedge clk);
      @(negedge clk);
      chk("b2b_idle_after", bus.s_ready_o, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
